// File: rtl/matrix_out_serializer_if.sv
// Valid/ready stream carrying one matrix entry and its index per transfer.
interface matrix_out_serializer_if #(
    parameter int EW = 10,
    parameter int IW = 4
);
    logic [EW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] index;

    modport master (
        output data_out,
        output out_valid,
        output index,
        input  out_ready
    );

    modport slave (
        input  data_out,
        input  out_valid,
        input  index,
        output out_ready
    );
endinterface

// File: rtl/matrix_out_serializer.sv
// Captures a result matrix on start and streams its entries one per transfer
// over a valid/ready interface, tolerating arbitrary back-pressure.
module matrix_out_serializer #(
    parameter int ENTRIES = 16,
    parameter int EW      = 10,
    parameter int IW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ENTRIES*EW-1:0] mat_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    matrix_out_serializer_if.master m
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          armed;
    logic [EW-1:0] mem [ENTRIES];
    logic          sending;

    assign sending = (state == SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            armed <= 1'b1;
            for (int k = 0; k < ENTRIES; k++) begin
                mem[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && armed) begin
                        for (int k = 0; k < ENTRIES; k++) begin
                            mem[k] <= mat_in[ENTRIES*EW-1-k*EW -: EW];
                        end
                        idx   <= '0;
                        armed <= 1'b0;
                        state <= SEND;
                    end else if (!start) begin
                        armed <= 1'b1;
                    end
                end
                SEND: begin
                    // Buffer is frozen here; only the consumer advances idx.
                    if (m.out_ready) begin
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                    if (!start) begin
                        armed <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign m.out_valid = sending;
    assign m.data_out  = sending ? mem[idx] : '0;
    assign m.index     = sending ? idx : '0;
    assign busy        = sending;
    assign done        = (state == DONE);
endmodule

// File: tb/tb_matrix_out_serializer.sv
// Directed bench for matrix_out_serializer: frames, stalls, re-arm, reset.
module tb_matrix_out_serializer;
    localparam int ENTRIES = 16;
    localparam int EW      = 10;
    localparam int IW      = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [ENTRIES*EW-1:0] mat_in = '0;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_v [ENTRIES];

    matrix_out_serializer_if #(.EW(EW), .IW(IW)) s_if ();

    matrix_out_serializer #(
        .ENTRIES(ENTRIES),
        .EW(EW),
        .IW(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mat_in(mat_in),
        .start(start),
        .busy(busy),
        .done(done),
        .m(s_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ENTRIES*EW-1:0] pack_exp();
        logic [ENTRIES*EW-1:0] r;
        r = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            r[ENTRIES*EW-1-k*EW -: EW] = exp_v[k];
        end
        return r;
    endfunction

    // Assumes cycle 1 of a frame (entry 0 offered); ends one cycle after done.
    task automatic drain(input string tag);
        s_if.out_ready = 1'b1;
        for (int k = 0; k < ENTRIES; k++) begin
            chk({tag, "_valid"}, 32'(s_if.out_valid), 32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_data"}, 32'(s_if.data_out), 32'(exp_v[k]));
            chk({tag, "_index"}, 32'(s_if.index), 32'(k));
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_valid_end"}, 32'(s_if.out_valid), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int e;
        int ntx;
        int nd;
        int cyc;
        logic rdy;
        s_if.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_valid", 32'(s_if.out_valid), 32'd0);
        chk("rst_data", 32'(s_if.data_out), 32'd0);
        chk("rst_index", 32'(s_if.index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic frame: entry k = k+1
        for (int k = 0; k < ENTRIES; k++) exp_v[k] = EW'(k + 1);
        mat_in = pack_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        drain("basic");

        // Back-pressure with pseudo-random ready
        start = 1'b1;
        step();
        start = 1'b0;
        e = 0;
        cyc = 0;
        while (e < ENTRIES && cyc < 400) begin
            rdy = 1'($urandom_range(0, 1));
            s_if.out_ready = rdy;
            chk("bp_valid", 32'(s_if.out_valid), 32'd1);
            chk("bp_data", 32'(s_if.data_out), 32'(exp_v[e]));
            chk("bp_index", 32'(s_if.index), 32'(e));
            chk("bp_nodone", 32'(done), 32'd0);
            step();
            if (rdy) e++;
            cyc++;
        end
        chk("bp_count", 32'(e), 32'(ENTRIES));
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_valid_end", 32'(s_if.out_valid), 32'd0);
        step();
        chk("bp_done_pulse", 32'(done), 32'd0);

        // Level start held high: one frame only
        s_if.out_ready = 1'b1;
        start = 1'b1;
        ntx = 0;
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            if (s_if.out_valid && s_if.out_ready) ntx++;
            step();
            if (done) nd++;
        end
        chk("level_transfers", 32'(ntx), 32'(ENTRIES));
        chk("level_dones", 32'(nd), 32'd1);
        chk("level_idle", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        drain("rearm");

        // Capture isolation
        for (int k = 0; k < ENTRIES; k++) exp_v[k] = EW'(10'h100 + k);
        mat_in = pack_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < ENTRIES; k++) mat_in[ENTRIES*EW-1-k*EW -: EW] = 10'h01F;
        drain("iso");

        // Reset mid-frame after the 5th transfer
        for (int k = 0; k < ENTRIES; k++) exp_v[k] = EW'(3 * k + 7);
        mat_in = pack_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("mid_index", 32'(s_if.index), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(s_if.out_valid), 32'd0);
        chk("mrst_data", 32'(s_if.data_out), 32'd0);
        chk("mrst_index", 32'(s_if.index), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        for (int k = 0; k < ENTRIES; k++) exp_v[k] = EW'(10'h200 + k);
        mat_in = pack_exp();
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_hold_done", 32'(done), 32'd0);
        step();
        start = 1'b0;
        drain("post_rst");

        // Max and mixed values
        for (int k = 0; k < ENTRIES; k++) begin
            case (k % 4)
                0: exp_v[k] = 10'h3FF;
                1: exp_v[k] = 10'h01F;
                2: exp_v[k] = 10'h010;
                default: exp_v[k] = 10'h2A5;
            endcase
        end
        mat_in = pack_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        drain("maxv");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
